noc_net_iface: RTL and testbench

//  PE-side network interface between one PE and its noc_router port. Egress: packs PE payload +

---
 rtl/noc_net_iface_pkg.sv | 22 ++
 rtl/noc_net_iface_if.sv | 39 +++
 rtl/noc_net_iface_fifo.sv | 48 ++++
 rtl/noc_net_iface.sv | 114 +++++++++++
 tb/tb_noc_net_iface.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_net_iface_pkg.sv
// Shared constants and state types for the PE-side NoC network interface.
// The flit layout constants must agree with the router's definitions.
package noc_net_iface_pkg;

  localparam int NOC_DATA_WIDTH   = 32;
  localparam int NOC_DEST_W       = 5;
  localparam int NOC_FIFO_DEPTH   = 4;
  localparam int FLIT_DEST_LSB    = 0;
  localparam int FLIT_DEST_MSB    = NOC_DEST_W - 1;
  localparam int FLIT_PAYLOAD_LSB = NOC_DEST_W;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

  typedef enum logic {
    PRIO_NET  = 1'b0,
    PRIO_LOOP = 1'b1
  } prio_e;

endpackage

// File: rtl/noc_net_iface_if.sv
// Handshake bundle between the network interface, its PE and its router port.
// slave = the interface block itself, master = the PE/router side driving it.
interface noc_net_iface_if
  import noc_net_iface_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEST_W     = NOC_DEST_W
);
  localparam int PAY_W = DATA_WIDTH - DEST_W;

  logic [PAY_W-1:0]      pe_tx_payload;
  logic [DEST_W-1:0]     pe_tx_dest;
  logic                  pe_tx_valid;
  logic                  pe_tx_ready;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  flit_out_valid;
  logic                  flit_out_ready;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  flit_in_valid;
  logic                  flit_in_ready;
  logic [PAY_W-1:0]      pe_rx_payload;
  logic                  pe_rx_valid;
  logic                  pe_rx_ready;

  modport slave (
    input  pe_tx_payload, pe_tx_dest, pe_tx_valid, flit_out_ready,
           flit_in, flit_in_valid, pe_rx_ready,
    output pe_tx_ready, flit_out, flit_out_valid, flit_in_ready,
           pe_rx_payload, pe_rx_valid
  );

  modport master (
    output pe_tx_payload, pe_tx_dest, pe_tx_valid, flit_out_ready,
           flit_in, flit_in_valid, pe_rx_ready,
    input  pe_tx_ready, flit_out, flit_out_valid, flit_in_ready,
           pe_rx_payload, pe_rx_valid
  );

endinterface

// File: rtl/noc_net_iface_fifo.sv
// Synchronous FIFO for the egress flit buffer; the head entry is always visible
// on rdata straight from the storage flops, so it is stable while not popped.
module noc_net_iface_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/noc_net_iface.sv
// PE-side network interface: egress flit buffer, ingress header strip, local loopback.
//   state    | meaning
//   RX_EMPTY | no payload held for the PE
//   RX_FULL  | pe_rx_payload holds a payload waiting for pe_rx_ready
module noc_net_iface
  import noc_net_iface_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEST_W     = NOC_DEST_W,
  parameter int FIFO_DEPTH = NOC_FIFO_DEPTH,
  localparam int PAY_W     = DATA_WIDTH - DEST_W,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DEST_W-1:0]  node_id,
  noc_net_iface_if.slave     bus,
  output logic [LVL_W-1:0]   tx_level,
  output logic [15:0]        stall_cnt,
  output logic               err_misroute
);

  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  head_local;
  logic                  out_valid;
  logic                  loop_req;
  logic                  loop_grant;
  logic                  slot_can_load;
  logic                  in_ready;
  logic                  net_accept;
  logic                  net_misroute;
  logic                  net_deliver;
  logic                  load;
  logic                  contended;
  rx_state_e             rx_state;
  rx_state_e             rx_next;
  prio_e                 prio;
  logic [PAY_W-1:0]      rx_payload;

  assign push = bus.pe_tx_valid && !fifo_full;

  noc_net_iface_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.pe_tx_payload, bus.pe_tx_dest}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (tx_level)
  );

  // A self-addressed head never goes to the router; it competes for the RX slot instead.
  assign head_local = (head[DEST_W-1:0] == node_id);
  assign out_valid  = !fifo_empty && !head_local;
  assign loop_req   = !fifo_empty && head_local;
  assign pop        = (out_valid && bus.flit_out_ready) || loop_grant;

  assign bus.pe_tx_ready    = !fifo_full;
  assign bus.flit_out_valid = out_valid;
  assign bus.flit_out       = out_valid ? head : '0;
  assign bus.flit_in_ready  = in_ready;
  assign bus.pe_rx_valid    = (rx_state == RX_FULL);
  assign bus.pe_rx_payload  = rx_payload;

  always_comb begin
    rx_next       = rx_state;
    slot_can_load = (rx_state == RX_EMPTY) || bus.pe_rx_ready;
    loop_grant    = slot_can_load && loop_req &&
                    (!bus.flit_in_valid || (prio == PRIO_LOOP));
    in_ready      = slot_can_load && !loop_grant;
    net_accept    = bus.flit_in_valid && in_ready;
    net_misroute  = (bus.flit_in[DEST_W-1:0] != node_id);
    net_deliver   = net_accept && !net_misroute;
    load          = loop_grant || net_deliver;
    // Misrouted flits are swallowed and do not advance the alternation.
    contended     = load && loop_req && bus.flit_in_valid;
    case (rx_state)
      RX_EMPTY: if (load) rx_next = RX_FULL;
      RX_FULL:  if (bus.pe_rx_ready && !load) rx_next = RX_EMPTY;
      default:  rx_next = RX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_EMPTY;
    else        rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_payload   <= '0;
      prio         <= PRIO_NET;
      stall_cnt    <= '0;
      err_misroute <= 1'b0;
    end else begin
      if (loop_grant)       rx_payload <= head[DATA_WIDTH-1:DEST_W];
      else if (net_deliver) rx_payload <= bus.flit_in[DATA_WIDTH-1:DEST_W];
      if (contended) prio <= (prio == PRIO_NET) ? PRIO_LOOP : PRIO_NET;
      if (out_valid && !bus.flit_out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (net_accept && net_misroute) err_misroute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed scenarios plus a randomized traffic run scored against per-source
// ordered queues for the PE-side network interface.
module tb_noc_net_iface;

  logic        clk;
  logic        rst_n;
  logic [4:0]  node_id;
  logic [2:0]  tx_level;
  logic [15:0] stall_cnt;
  logic        err_misroute;

  int errors = 0;
  int checks = 0;

  noc_net_iface_if #(.DATA_WIDTH(32), .DEST_W(5)) bus ();

  noc_net_iface dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .node_id      (node_id),
    .bus          (bus),
    .tx_level     (tx_level),
    .stall_cnt    (stall_cnt),
    .err_misroute (err_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_level"},   32'(tx_level), 0);
    check({tag, "_tx_ready"},   32'(bus.pe_tx_ready), 1);
    check({tag, "_fo_valid"},   32'(bus.flit_out_valid), 0);
    check({tag, "_flit_out"},   bus.flit_out, 0);
    check({tag, "_rx_valid"},   32'(bus.pe_rx_valid), 0);
    check({tag, "_rx_payload"}, 32'(bus.pe_rx_payload), 0);
    check({tag, "_in_ready"},   32'(bus.flit_in_ready), 1);
    check({tag, "_stall"},      32'(stall_cnt), 0);
    check({tag, "_misroute"},   32'(err_misroute), 0);
  endtask

  logic [26:0] p;
  logic [26:0] got_q [$];
  logic [26:0] exp4 [8];
  logic [31:0] g;
  int          nidx;

  // random-phase reference state: per-source FIFO order is all the spec guarantees
  logic [31:0] rq [$];
  logic [26:0] lq [$];
  logic [26:0] nq [$];
  logic        net_pending;
  logic [31:0] net_flit;
  logic [4:0]  d;
  logic [31:0] e;
  int          lcnt;
  int          ncnt;
  logic        stop;

  initial begin
    rst_n = 1'b0;
    node_id = 5'd0;
    bus.pe_tx_payload = '0;
    bus.pe_tx_dest = '0;
    bus.pe_tx_valid = 1'b0;
    bus.flit_out_ready = 1'b1;
    bus.flit_in = '0;
    bus.flit_in_valid = 1'b0;
    bus.pe_rx_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three remote packets stream out back to back
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pe_tx_valid = (i < 3);
      bus.pe_tx_payload = 27'h0A0 + 27'(i);
      bus.pe_tx_dest = 5'd2;
      #1;
      if (i == 0) check("t1_idle_valid", 32'(bus.flit_out_valid), 0);
      if (i >= 1 && i <= 3) begin
        p = 27'h0A0 + 27'(i - 1);
        check("t1_valid", 32'(bus.flit_out_valid), 1);
        check("t1_flit", bus.flit_out, {p, 5'd2});
      end
      if (i == 4) begin
        check("t1_done_valid", 32'(bus.flit_out_valid), 0);
        check("t1_level", 32'(tx_level), 0);
      end
    end

    // 2: blocked router, FIFO fills, stall counter runs, order preserved
    #1;
    check("t2_stall_start", 32'(stall_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.flit_out_ready = 1'b0;
      bus.pe_tx_valid = 1'b1;
      bus.pe_tx_payload = 27'h0B0 + 27'(i);
      bus.pe_tx_dest = 5'd2;
      #1;
      check("t2_tx_ready", 32'(bus.pe_tx_ready), (i < 4) ? 1 : 0);
    end
    @(negedge clk);
    bus.pe_tx_valid = 1'b0;
    #1;
    check("t2_level_full", 32'(tx_level), 4);
    check("t2_stall4", 32'(stall_cnt), 4);
    @(negedge clk);
    #1;
    check("t2_stall5", 32'(stall_cnt), 5);
    bus.flit_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = 27'h0B0 + 27'(i);
      #1;
      check("t2_order_valid", 32'(bus.flit_out_valid), 1);
      check("t2_order", bus.flit_out, {p, 5'd2});
      @(negedge clk);
    end
    #1;
    check("t2_drained_valid", 32'(bus.flit_out_valid), 0);
    check("t2_drained_level", 32'(tx_level), 0);
    check("t2_stall_hold", 32'(stall_cnt), 5);

    // 3: loopback reaches the PE two cycles after the push
    @(negedge clk);
    node_id = 5'd7;
    bus.pe_tx_valid = 1'b1;
    bus.pe_tx_dest = 5'd7;
    bus.pe_tx_payload = 27'h1234;
    #1;
    check("t3_rx_pre", 32'(bus.pe_rx_valid), 0);
    @(negedge clk);
    bus.pe_tx_valid = 1'b0;
    #1;
    check("t3_fo_c1", 32'(bus.flit_out_valid), 0);
    check("t3_rx_c1", 32'(bus.pe_rx_valid), 0);
    @(negedge clk);
    #1;
    check("t3_rx_c2", 32'(bus.pe_rx_valid), 1);
    check("t3_payload", 32'(bus.pe_rx_payload), 32'h1234);
    check("t3_fo_c2", 32'(bus.flit_out_valid), 0);
    check("t3_level", 32'(tx_level), 0);
    @(negedge clk);
    #1;
    check("t3_rx_drained", 32'(bus.pe_rx_valid), 0);

    // 4: continuous network traffic against two loopback packets
    exp4 = '{27'h100, 27'h101, 27'h200, 27'h102, 27'h201, 27'h103, 27'h104, 27'h105};
    nidx = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.pe_tx_valid = (c < 2);
      bus.pe_tx_dest = 5'd7;
      bus.pe_tx_payload = 27'h200 + 27'(c);
      bus.flit_in_valid = (nidx < 6);
      bus.flit_in = {27'h100 + 27'(nidx), 5'd7};
      #1;
      if (bus.pe_rx_valid && bus.pe_rx_ready) got_q.push_back(bus.pe_rx_payload);
      if (bus.flit_in_valid && bus.flit_in_ready) nidx++;
    end
    bus.flit_in_valid = 1'b0;
    bus.pe_tx_valid = 1'b0;
    check("t4_count", 32'(got_q.size()), 8);
    for (int k = 0; k < 8; k++) begin
      g = (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF;
      check($sformatf("t4_seq%0d", k), g, 32'(exp4[k]));
    end

    // 5: misrouted flit is consumed, flagged, not delivered
    @(negedge clk);
    node_id = 5'd1;
    bus.flit_in_valid = 1'b1;
    bus.flit_in = {27'h3AA, 5'd3};
    #1;
    check("t5_in_ready", 32'(bus.flit_in_ready), 1);
    check("t5_err_pre", 32'(err_misroute), 0);
    @(negedge clk);
    bus.flit_in_valid = 1'b0;
    #1;
    check("t5_err", 32'(err_misroute), 1);
    check("t5_no_rx", 32'(bus.pe_rx_valid), 0);
    @(negedge clk);
    #1;
    check("t5_err_sticky", 32'(err_misroute), 1);

    // 6: PE stalls with slot full, then asynchronous reset mid-stall
    @(negedge clk);
    bus.pe_rx_ready = 1'b0;
    bus.flit_out_ready = 1'b0;
    bus.flit_in_valid = 1'b1;
    bus.flit_in = {27'h0C1, 5'd1};
    #1;
    check("t6_in_ready0", 32'(bus.flit_in_ready), 1);
    @(negedge clk);
    bus.flit_in = {27'h0C2, 5'd1};
    bus.pe_tx_valid = 1'b1;
    bus.pe_tx_dest = 5'd4;
    bus.pe_tx_payload = 27'h0D0;
    #1;
    check("t6_rx_valid", 32'(bus.pe_rx_valid), 1);
    check("t6_payload", 32'(bus.pe_rx_payload), 32'h0C1);
    check("t6_in_blocked", 32'(bus.flit_in_ready), 0);
    @(negedge clk);
    bus.pe_tx_valid = 1'b0;
    #1;
    check("t6_payload_stable", 32'(bus.pe_rx_payload), 32'h0C1);
    check("t6_in_blocked2", 32'(bus.flit_in_ready), 0);
    check("t6_level", 32'(tx_level), 1);
    #1;
    rst_n = 1'b0;
    bus.flit_in_valid = 1'b0;
    #1;
    check_reset_values("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    bus.pe_rx_ready = 1'b1;
    bus.flit_out_ready = 1'b1;
    #1;
    check("t6_post_level", 32'(tx_level), 0);
    @(negedge clk);
    #1;
    check("t6_post_level2", 32'(tx_level), 0);
    check("t6_post_fo", 32'(bus.flit_out_valid), 0);
    check("t6_post_rx", 32'(bus.pe_rx_valid), 0);

    // random traffic: remote, loopback and network flits with random back-pressure
    node_id = 5'd9;
    net_pending = 1'b0;
    net_flit = '0;
    lcnt = 0;
    ncnt = 0;
    for (int c = 0; c < 1200; c++) begin
      stop = (c >= 700);
      if (stop && rq.size() == 0 && lq.size() == 0 && nq.size() == 0 && !net_pending) break;
      @(negedge clk);
      bus.pe_rx_ready = stop ? 1'b1 : ($urandom_range(3) != 0);
      bus.flit_out_ready = stop ? 1'b1 : ($urandom_range(3) != 0);
      bus.pe_tx_valid = !stop && ($urandom_range(1) == 1);
      if ($urandom_range(2) == 0) d = node_id;
      else d = node_id + 5'd1 + 5'($urandom_range(30));
      bus.pe_tx_dest = d;
      if (d == node_id) bus.pe_tx_payload = {1'b0, 10'h0, 16'(lcnt)};
      else bus.pe_tx_payload = 27'($urandom);
      if (!net_pending && !stop && ($urandom_range(1) == 1)) begin
        net_pending = 1'b1;
        net_flit = {1'b1, 10'h0, 16'(ncnt), node_id};
        ncnt++;
      end
      bus.flit_in_valid = net_pending;
      bus.flit_in = net_flit;
      #1;
      if (bus.pe_rx_valid) begin
        if (bus.pe_rx_payload[26]) begin
          e = (nq.size() > 0) ? 32'(nq[0]) : 32'hFFFF_FFFF;
          check("rnd_rx_net", 32'(bus.pe_rx_payload), e);
          if (bus.pe_rx_ready && nq.size() > 0) void'(nq.pop_front());
        end else begin
          e = (lq.size() > 0) ? 32'(lq[0]) : 32'hFFFF_FFFF;
          check("rnd_rx_loop", 32'(bus.pe_rx_payload), e);
          if (bus.pe_rx_ready && lq.size() > 0) void'(lq.pop_front());
        end
      end
      if (bus.flit_out_valid) begin
        e = (rq.size() > 0) ? rq[0] : 32'hFFFF_FFFF;
        check("rnd_flit_out", bus.flit_out, e);
        if (bus.flit_out_ready && rq.size() > 0) void'(rq.pop_front());
      end
      if (bus.pe_tx_valid && bus.pe_tx_ready) begin
        if (d == node_id) begin
          lq.push_back(bus.pe_tx_payload);
          lcnt++;
        end else begin
          rq.push_back({bus.pe_tx_payload, d});
        end
      end
      if (bus.flit_in_valid && bus.flit_in_ready) begin
        nq.push_back(net_flit[31:5]);
        net_pending = 1'b0;
      end
    end
    bus.pe_tx_valid = 1'b0;
    bus.flit_in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rnd_remote_left", 32'(rq.size()), 0);
    check("rnd_loop_left", 32'(lq.size()), 0);
    check("rnd_net_left", 32'(nq.size()), 0);
    check("rnd_net_pending", 32'(net_pending), 0);
    check("rnd_end_rx", 32'(bus.pe_rx_valid), 0);
    check("rnd_end_level", 32'(tx_level), 0);
    check("rnd_no_misroute", 32'(err_misroute), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
